// File: rtl/ex_wb_if.sv
// EX->WB boundary bundle: EX-stage slot inputs, WB/SR/forwarding/redirect outputs.
interface ex_wb_if;
  logic        stall;
  logic        ex_vld;
  logic [31:0] ex_rslt;
  logic [3:0]  ex_wreg;
  logic        ex_wen;
  logic        ex_tbit, ex_qbit, ex_mbit;
  logic        ex_twen, ex_qwen, ex_mwen;
  logic [31:0] ex_addr;
  logic        ex_br;
  logic        ex_dly;
  logic [3:0]  rd_reg;
  logic        wb_vld;
  logic        wb_wen;
  logic [3:0]  wb_wreg;
  logic [31:0] wb_wdata;
  logic        sr_t, sr_q, sr_m;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        redir;
  logic [31:0] redir_pc;
  logic        squash;

  modport slave (
    input  stall, ex_vld, ex_rslt, ex_wreg, ex_wen,
           ex_tbit, ex_qbit, ex_mbit, ex_twen, ex_qwen, ex_mwen,
           ex_addr, ex_br, ex_dly, rd_reg,
    output wb_vld, wb_wen, wb_wreg, wb_wdata, sr_t, sr_q, sr_m,
           fwd_hit, fwd_data, redir, redir_pc, squash
  );

  modport master (
    output stall, ex_vld, ex_rslt, ex_wreg, ex_wen,
           ex_tbit, ex_qbit, ex_mbit, ex_twen, ex_qwen, ex_mwen,
           ex_addr, ex_br, ex_dly, rd_reg,
    input  wb_vld, wb_wen, wb_wreg, wb_wdata, sr_t, sr_q, sr_m,
           fwd_hit, fwd_data, redir, redir_pc, squash
  );
endinterface

// File: rtl/ex_wb.sv
// EX->WB pipeline register with SR flag update, WB forwarding and the
// branch redirect / delay-slot / squash control FSM.
module ex_wb #(
  parameter int unsigned SQ_DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  ex_wb_if.slave   bus
);

  typedef enum logic [1:0] {RUN, DSLOT, SQ} state_e;

  localparam logic [1:0] SQ_INIT     = 2'(SQ_DEPTH);
  localparam logic [1:0] SQ_AFTER_DS = 2'(SQ_DEPTH - 1);

  state_e      state_q, state_d;
  logic [1:0]  sq_cnt_q, sq_cnt_d;
  logic        wb_vld_q, wb_vld_d;
  logic        wb_wen_q, wb_wen_d;
  logic [3:0]  wb_wreg_q, wb_wreg_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;
  logic        sr_t_q, sr_t_d, sr_q_q, sr_q_d, sr_m_q, sr_m_d;
  logic        redir_q, redir_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic take, commit, br_take, squash;

  // A slot "takes" a step whenever it is valid and not stalled; in SQ it is killed instead of committed.
  assign take    = bus.ex_vld & ~bus.stall;
  assign squash  = (state_q == SQ) & bus.ex_vld;
  assign commit  = take & (state_q != SQ);
  assign br_take = commit & (state_q == RUN) & bus.ex_br;

  always_comb begin
    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    case (state_q)
      RUN: begin
        if (br_take) begin
          if (bus.ex_dly) begin
            state_d = DSLOT;
          end else begin
            state_d  = SQ;
            sq_cnt_d = SQ_INIT;
          end
        end
      end
      DSLOT: begin
        if (take) begin
          if (SQ_DEPTH == 1) begin
            state_d  = RUN;
            sq_cnt_d = 2'd0;
          end else begin
            state_d  = SQ;
            sq_cnt_d = SQ_AFTER_DS;
          end
        end
      end
      SQ: begin
        if (take) begin
          sq_cnt_d = sq_cnt_q - 2'd1;
          if (sq_cnt_q <= 2'd1) state_d = RUN;
        end
      end
      default: begin
        state_d  = RUN;
        sq_cnt_d = 2'd0;
      end
    endcase
  end

  always_comb begin
    wb_vld_d   = wb_vld_q;
    wb_wen_d   = wb_wen_q;
    wb_wreg_d  = wb_wreg_q;
    wb_wdata_d = wb_wdata_q;
    sr_t_d     = sr_t_q;
    sr_q_d     = sr_q_q;
    sr_m_d     = sr_m_q;
    if (!bus.stall) begin
      wb_vld_d = commit;
      wb_wen_d = commit & bus.ex_wen;
    end
    if (commit) begin
      wb_wreg_d  = bus.ex_wreg;
      wb_wdata_d = bus.ex_rslt;
      // Flag bits are muxed by their enables so undriven values never reach SR.
      if (bus.ex_twen) sr_t_d = bus.ex_tbit;
      if (bus.ex_qwen) sr_q_d = bus.ex_qbit;
      if (bus.ex_mwen) sr_m_d = bus.ex_mbit;
    end
    redir_d    = br_take;
    redir_pc_d = br_take ? bus.ex_addr : redir_pc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      sq_cnt_q   <= 2'd0;
      wb_vld_q   <= 1'b0;
      wb_wen_q   <= 1'b0;
      wb_wreg_q  <= 4'd0;
      wb_wdata_q <= 32'd0;
      sr_t_q     <= 1'b0;
      sr_q_q     <= 1'b0;
      sr_m_q     <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      sq_cnt_q   <= sq_cnt_d;
      wb_vld_q   <= wb_vld_d;
      wb_wen_q   <= wb_wen_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_wdata_q <= wb_wdata_d;
      sr_t_q     <= sr_t_d;
      sr_q_q     <= sr_q_d;
      sr_m_q     <= sr_m_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign bus.wb_vld   = wb_vld_q;
  assign bus.wb_wen   = wb_wen_q & wb_vld_q;
  assign bus.wb_wreg  = wb_wreg_q;
  assign bus.wb_wdata = wb_wdata_q;
  assign bus.sr_t     = sr_t_q;
  assign bus.sr_q     = sr_q_q;
  assign bus.sr_m     = sr_m_q;
  assign bus.fwd_hit  = bus.wb_wen & (wb_wreg_q == bus.rd_reg);
  assign bus.fwd_data = bus.fwd_hit ? wb_wdata_q : 32'd0;
  assign bus.redir    = redir_q;
  assign bus.redir_pc = redir_pc_q;
  assign bus.squash   = squash;

endmodule

// File: tb/tb_ex_wb.sv
// Bench for ex_wb: directed vector table, a mid-squash reset sequence, and
// randomized traffic checked against a counter-based behavioural model.
module tb_ex_wb;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_wb_if bus ();
  ex_wb #(.SQ_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        st, v;
    logic [31:0] rslt;
    logic [3:0]  wreg;
    logic        wen;
    logic [2:0]  fl, fwe;
    logic [31:0] addr;
    logic        br, dly;
    logic [3:0]  rd;
    logic        e_sq, e_fh;
    logic [31:0] e_fd;
    logic        e_wv, e_we;
    logic [3:0]  e_wr;
    logic [31:0] e_wd;
    logic [2:0]  e_sr;
    logic        e_rd;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [24];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic drive(vec_t r);
    bus.stall   = r.st;
    bus.ex_vld  = r.v;
    bus.ex_rslt = r.rslt;
    bus.ex_wreg = r.wreg;
    bus.ex_wen  = r.wen;
    {bus.ex_tbit, bus.ex_qbit, bus.ex_mbit} = r.fl;
    {bus.ex_twen, bus.ex_qwen, bus.ex_mwen} = r.fwe;
    bus.ex_addr = r.addr;
    bus.ex_br   = r.br;
    bus.ex_dly  = r.dly;
    bus.rd_reg  = r.rd;
  endtask

  task automatic run_vec(int i);
    vec_t r;
    r = tbl[i];
    drive(r);
    @(negedge clk);
    chk($sformatf("v%0d squash", i),   32'(bus.squash),  32'(r.e_sq));
    chk($sformatf("v%0d fwd_hit", i),  32'(bus.fwd_hit), 32'(r.e_fh));
    chk($sformatf("v%0d fwd_data", i), bus.fwd_data,     r.e_fd);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d wb_vld", i),   32'(bus.wb_vld),  32'(r.e_wv));
    chk($sformatf("v%0d wb_wen", i),   32'(bus.wb_wen),  32'(r.e_we));
    chk($sformatf("v%0d wb_wreg", i),  32'(bus.wb_wreg), 32'(r.e_wr));
    chk($sformatf("v%0d wb_wdata", i), bus.wb_wdata,     r.e_wd);
    chk($sformatf("v%0d sr", i), 32'({bus.sr_t, bus.sr_q, bus.sr_m}), 32'(r.e_sr));
    chk($sformatf("v%0d redir", i),    32'(bus.redir),   32'(r.e_rd));
    chk($sformatf("v%0d redir_pc", i), bus.redir_pc,     r.e_pc);
  endtask

  task automatic check_reset(string tag);
    chk({tag, " wb_vld"},   32'(bus.wb_vld),   32'd0);
    chk({tag, " wb_wen"},   32'(bus.wb_wen),   32'd0);
    chk({tag, " wb_wreg"},  32'(bus.wb_wreg),  32'd0);
    chk({tag, " wb_wdata"}, bus.wb_wdata,      32'd0);
    chk({tag, " sr"}, 32'({bus.sr_t, bus.sr_q, bus.sr_m}), 32'd0);
    chk({tag, " redir"},    32'(bus.redir),    32'd0);
    chk({tag, " redir_pc"}, bus.redir_pc,      32'd0);
    chk({tag, " squash"},   32'(bus.squash),   32'd0);
  endtask

  // Behavioural model state: pending kills and a delay-slot-owed flag.
  int          m_kill;
  bit          m_dslot;
  logic        m_wv, m_we, m_rd;
  logic [3:0]  m_wr;
  logic [31:0] m_wd, m_pc;
  logic [2:0]  m_sr;

  task automatic model_reset();
    m_kill = 0; m_dslot = 0;
    m_wv = 0; m_we = 0; m_rd = 0; m_wr = '0; m_wd = '0; m_pc = '0; m_sr = '0;
  endtask

  task automatic model_step();
    bit commit;
    logic [2:0] fl, fwe;
    commit = bus.ex_vld && !bus.stall && (m_kill == 0);
    if (bus.ex_vld && !bus.stall && m_kill > 0) m_kill--;
    m_rd = 1'b0;
    if (commit) begin
      if (m_dslot) begin
        m_dslot = 0;
        m_kill  = DEPTH - 1;
      end else if (bus.ex_br) begin
        m_rd = 1'b1;
        m_pc = bus.ex_addr;
        if (bus.ex_dly) m_dslot = 1;
        else            m_kill  = DEPTH;
      end
      fl  = {bus.ex_tbit, bus.ex_qbit, bus.ex_mbit};
      fwe = {bus.ex_twen, bus.ex_qwen, bus.ex_mwen};
      m_sr = (m_sr & ~fwe) | (fl & fwe);
      m_wr = bus.ex_wreg;
      m_wd = bus.ex_rslt;
    end
    if (!bus.stall) begin
      m_wv = commit;
      m_we = commit && bus.ex_wen;
    end
  endtask

  initial begin
    tbl = '{
      // ADD to R3, then forward it
      '{1'b0,1'b1,32'h12345678,4'd3,1'b1,3'b000,3'b000,32'h0,1'b0,1'b0,4'd0, 1'b0,1'b0,32'h0, 1'b1,1'b1,4'd3,32'h12345678,3'b000,1'b0,32'h0},
      '{1'b0,1'b0,32'h0,4'd0,1'b0,3'b000,3'b000,32'h0,1'b0,1'b0,4'd3, 1'b0,1'b1,32'h12345678, 1'b0,1'b0,4'd3,32'h12345678,3'b000,1'b0,32'h0},
      // CMP sets T; next commit with T disabled holds it; DIV0S q=1 m=0
      '{1'b0,1'b1,32'h1,4'd0,1'b0,3'b100,3'b100,32'h0,1'b0,1'b0,4'd3, 1'b0,1'b0,32'h0, 1'b1,1'b0,4'd0,32'h1,3'b100,1'b0,32'h0},
      '{1'b0,1'b1,32'h2,4'd1,1'b0,3'b011,3'b000,32'h0,1'b0,1'b0,4'd0, 1'b0,1'b0,32'h0, 1'b1,1'b0,4'd1,32'h2,3'b100,1'b0,32'h0},
      '{1'b0,1'b1,32'hA,4'd2,1'b1,3'b010,3'b011,32'h0,1'b0,1'b0,4'd1, 1'b0,1'b0,32'h0, 1'b1,1'b1,4'd2,32'hA,3'b110,1'b0,32'h0},
      // non-delayed branch to 0x400, two squashed slots around a stall bubble, third commits
      '{1'b0,1'b1,32'h0,4'd0,1'b0,3'b000,3'b000,32'h400,1'b1,1'b0,4'd2, 1'b0,1'b1,32'hA, 1'b1,1'b0,4'd0,32'h0,3'b110,1'b1,32'h400},
      '{1'b0,1'b1,32'hDEAD,4'd7,1'b1,3'b111,3'b111,32'h0,1'b0,1'b0,4'd0, 1'b1,1'b0,32'h0, 1'b0,1'b0,4'd0,32'h0,3'b110,1'b0,32'h400},
      '{1'b1,1'b1,32'hDEAD,4'd7,1'b1,3'b111,3'b111,32'h0,1'b0,1'b0,4'd0, 1'b1,1'b0,32'h0, 1'b0,1'b0,4'd0,32'h0,3'b110,1'b0,32'h400},
      '{1'b0,1'b1,32'hBEEF,4'd8,1'b1,3'b111,3'b111,32'h0,1'b1,1'b0,4'd0, 1'b1,1'b0,32'h0, 1'b0,1'b0,4'd0,32'h0,3'b110,1'b0,32'h400},
      '{1'b0,1'b1,32'h99,4'd9,1'b1,3'b000,3'b000,32'h0,1'b0,1'b0,4'd0, 1'b0,1'b0,32'h0, 1'b1,1'b1,4'd9,32'h99,3'b110,1'b0,32'h400},
      // delayed branch to 0x80, idle cycle, delay slot writes R5 with ex_br set, one squashed slot
      '{1'b0,1'b1,32'h0,4'd0,1'b0,3'b000,3'b000,32'h80,1'b1,1'b1,4'd9, 1'b0,1'b1,32'h99, 1'b1,1'b0,4'd0,32'h0,3'b110,1'b1,32'h80},
      '{1'b0,1'b0,32'h11,4'd1,1'b1,3'b000,3'b000,32'h0,1'b0,1'b0,4'd0, 1'b0,1'b0,32'h0, 1'b0,1'b0,4'd0,32'h0,3'b110,1'b0,32'h80},
      '{1'b0,1'b1,32'h55,4'd5,1'b1,3'b000,3'b000,32'h1000,1'b1,1'b0,4'd0, 1'b0,1'b0,32'h0, 1'b1,1'b1,4'd5,32'h55,3'b110,1'b0,32'h80},
      '{1'b0,1'b1,32'h66,4'd6,1'b1,3'b000,3'b000,32'h0,1'b0,1'b0,4'd5, 1'b1,1'b1,32'h55, 1'b0,1'b0,4'd5,32'h55,3'b110,1'b0,32'h80},
      '{1'b0,1'b1,32'h44,4'd4,1'b1,3'b000,3'b000,32'h0,1'b0,1'b0,4'd5, 1'b0,1'b0,32'h0, 1'b1,1'b1,4'd4,32'h44,3'b110,1'b0,32'h80},
      // four stalled cycles carrying a would-be branch, then release
      '{1'b1,1'b1,32'hAA,4'd10,1'b1,3'b111,3'b111,32'h200,1'b1,1'b0,4'd4, 1'b0,1'b1,32'h44, 1'b1,1'b1,4'd4,32'h44,3'b110,1'b0,32'h80},
      '{1'b1,1'b1,32'hAA,4'd10,1'b1,3'b111,3'b111,32'h200,1'b1,1'b0,4'd4, 1'b0,1'b1,32'h44, 1'b1,1'b1,4'd4,32'h44,3'b110,1'b0,32'h80},
      '{1'b1,1'b1,32'hAA,4'd10,1'b1,3'b111,3'b111,32'h200,1'b1,1'b0,4'd4, 1'b0,1'b1,32'h44, 1'b1,1'b1,4'd4,32'h44,3'b110,1'b0,32'h80},
      '{1'b1,1'b1,32'hAA,4'd10,1'b1,3'b111,3'b111,32'h200,1'b1,1'b0,4'd4, 1'b0,1'b1,32'h44, 1'b1,1'b1,4'd4,32'h44,3'b110,1'b0,32'h80},
      '{1'b0,1'b1,32'hBB,4'd11,1'b1,3'b000,3'b000,32'h0,1'b0,1'b0,4'd4, 1'b0,1'b1,32'h44, 1'b1,1'b1,4'd11,32'hBB,3'b110,1'b0,32'h80},
      // branch then one squashed slot (one kill left) before the mid-squash reset
      '{1'b0,1'b1,32'h0,4'd0,1'b0,3'b000,3'b000,32'h300,1'b1,1'b0,4'd0, 1'b0,1'b0,32'h0, 1'b1,1'b0,4'd0,32'h0,3'b110,1'b1,32'h300},
      '{1'b0,1'b1,32'h77,4'd7,1'b1,3'b000,3'b000,32'h0,1'b0,1'b0,4'd0, 1'b1,1'b0,32'h0, 1'b0,1'b0,4'd0,32'h0,3'b110,1'b0,32'h300},
      // after reset: first slot commits, pipeline back in normal flow
      '{1'b0,1'b1,32'hCC,4'd12,1'b1,3'b000,3'b000,32'h0,1'b0,1'b0,4'd0, 1'b0,1'b0,32'h0, 1'b1,1'b1,4'd12,32'hCC,3'b000,1'b0,32'h0},
      '{1'b0,1'b1,32'hDD,4'd13,1'b1,3'b000,3'b000,32'h0,1'b0,1'b0,4'd12, 1'b0,1'b1,32'hCC, 1'b1,1'b1,4'd13,32'hDD,3'b000,1'b0,32'h0}
    };

    rst = 1'b0;
    drive(tbl[1]);
    bus.ex_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b1;

    for (int i = 0; i < 22; i++) run_vec(i);

    // Reset lands mid-squash with a valid slot on the input.
    bus.ex_vld  = 1'b1;
    bus.ex_wen  = 1'b1;
    bus.ex_wreg = 4'd12;
    bus.ex_rslt = 32'hCC;
    bus.ex_br   = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_reset("midsq");
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 22; i < 24; i++) run_vec(i);

    // Randomized traffic against the model.
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic        e_sq, e_fh;
      logic [31:0] e_fd;
      bus.stall   = ($urandom_range(0, 99) < 20);
      bus.ex_vld  = ($urandom_range(0, 99) < 75);
      bus.ex_rslt = $urandom;
      bus.ex_wreg = 4'($urandom);
      bus.ex_wen  = 1'($urandom);
      {bus.ex_tbit, bus.ex_qbit, bus.ex_mbit} = 3'($urandom);
      {bus.ex_twen, bus.ex_qwen, bus.ex_mwen} = 3'($urandom);
      bus.ex_addr = $urandom;
      bus.ex_br   = ($urandom_range(0, 99) < 20);
      bus.ex_dly  = 1'($urandom);
      bus.rd_reg  = 4'($urandom);
      @(negedge clk);
      e_sq = bus.ex_vld && (m_kill > 0);
      e_fh = m_we && (m_wr == bus.rd_reg);
      e_fd = e_fh ? m_wd : 32'd0;
      chk($sformatf("rnd%0d squash", c),   32'(bus.squash),  32'(e_sq));
      chk($sformatf("rnd%0d fwd_hit", c),  32'(bus.fwd_hit), 32'(e_fh));
      chk($sformatf("rnd%0d fwd_data", c), bus.fwd_data,     e_fd);
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("rnd%0d wb_vld", c),   32'(bus.wb_vld),  32'(m_wv));
      chk($sformatf("rnd%0d wb_wen", c),   32'(bus.wb_wen),  32'(m_we));
      chk($sformatf("rnd%0d wb_wreg", c),  32'(bus.wb_wreg), 32'(m_wr));
      chk($sformatf("rnd%0d wb_wdata", c), bus.wb_wdata,     m_wd);
      chk($sformatf("rnd%0d sr", c), 32'({bus.sr_t, bus.sr_q, bus.sr_m}), 32'(m_sr));
      chk($sformatf("rnd%0d redir", c),    32'(bus.redir),   32'(m_rd));
      chk($sformatf("rnd%0d redir_pc", c), bus.redir_pc,     m_pc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_wb.md
EX_WB -- requirements
Module: ex_wb

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter SQ_DEPTH, default 2: younger slots squashed after a taken non-delayed branch (legal 1..3).
REQ-003 Ports SHALL be, one per line (name  direction  width  meaning):
 clk  in  1  clock
 rst  in  1  async reset, active-low
 stall  in  1  pipeline hold; no state advance
 ex_vld  in  1  EX slot holds a valid instruction
 ex_rslt  in  32  EX result
 ex_wreg  in  4  destination GPR
 ex_wen  in  1  GPR write request
 ex_tbit/ex_qbit/ex_mbit  in  1 each  new SR flag values
 ex_twen/ex_qwen/ex_mwen  in  1 each  SR flag write enables
 ex_addr  in  32  branch target from EX adder
 ex_br  in  1  taken branch in EX
 ex_dly  in  1  branch is delayed (BTS/BFS/BRA class)
 rd_reg  in  4  GPR index read by the next EX operand
 wb_vld  out  1  WB slot valid
 wb_wen  out  1  GPR write strobe
 wb_wreg  out  4  GPR write index
 wb_wdata  out  32  GPR write data
 sr_t/sr_q/sr_m  out  1 each  architectural SR flags
 fwd_hit  out  1  rd_reg matches a pending WB write
 fwd_data  out  32  forwarded value
 redir  out  1  one-cycle fetch redirect pulse
 redir_pc  out  32  redirect target
 squash  out  1  current EX slot is being killed

Function
REQ-004 Slot accepted ("commit") when ex_vld=1, stall=0, squash=0.
REQ-005 On commit, WB register SHALL capture ex_rslt, ex_wreg, ex_wen; wb_vld=1 next cycle.
REQ-006 No commit and stall=0: wb_vld, wb_wen SHALL clear next cycle; stall=1: all WB state holds.
REQ-007 wb_wen SHALL equal registered ex_wen AND wb_vld.
REQ-008 On commit, each SR flag with write enable SHALL load its new value next cycle; flags without enable hold.
REQ-009 ex_* flag bits of X when enable=0 SHALL NOT propagate into sr_t/q/m.
REQ-010 fwd_hit SHALL be combinational: wb_wen=1 and wb_wreg==rd_reg; fwd_data=wb_wdata; fwd_data=0 when fwd_hit=0.
REQ-011 Control FSM states: RUN, DSLOT, SQ; 2-bit counter sq_cnt.
REQ-012 RUN: commit with ex_br=1, ex_dly=0 -> SQ, sq_cnt=SQ_DEPTH; with ex_dly=1 -> DSLOT.
REQ-013 redir SHALL pulse exactly one cycle, registered, the cycle after the branch commit, redir_pc=captured ex_addr; both cases.
REQ-014 DSLOT: next ex_vld non-stalled slot commits normally (delay slot); then -> SQ, sq_cnt=SQ_DEPTH-1; SQ_DEPTH=1 returns to RUN.
REQ-015 ex_br asserted on the delay-slot instruction SHALL be ignored (no redirect, no re-entry).
REQ-016 SQ: squash=ex_vld; each ex_vld non-stalled slot decrements sq_cnt, no WB/SR update; sq_cnt reaching 0 -> RUN.
REQ-017 ex_vld=0 or stall=1 cycles SHALL NOT advance DSLOT or SQ.
REQ-018 squash SHALL be 0 in RUN and DSLOT.
REQ-019 Write-through latency: commit at cycle N -> wb_wen/sr_* visible N+1.

Reset
REQ-020 rst=0 SHALL asynchronously force: wb_vld=0, wb_wen=0, wb_wreg=0, wb_wdata=0, sr_t=0, sr_q=0, sr_m=0, redir=0, redir_pc=0, FSM=RUN, sq_cnt=0.
REQ-021 Reset during SQ/DSLOT SHALL abandon squash; first post-reset slot commits.
REQ-022 Outputs SHALL be glitch-free registered except fwd_hit, fwd_data, squash.

Verification
REQ-023 ADD commit ex_rslt=0x12345678, ex_wreg=3, ex_wen=1 -> next cycle wb_wen=1, wb_wreg=3, wb_wdata=0x12345678; rd_reg=3 -> fwd_hit=1, fwd_data=0x12345678.
REQ-024 CMP commit ex_twen=1, ex_tbit=1, then commit ex_twen=0, ex_tbit=X -> sr_t=1 holds; DIV0S qwen/mwen=1, q=1, m=0 -> sr_q=1, sr_m=0.
REQ-025 Non-delayed branch ex_addr=0x00000400, SQ_DEPTH=2, then 3 valid slots with one stall bubble between -> redir one cycle, redir_pc=0x400, first two valid slots squash=1 with no WB, third commits.
REQ-026 Delayed branch ex_addr=0x80, delay slot ex_wen=1 wreg=5, delay slot has ex_br=1 -> delay slot writes R5, no second redirect, next 1 valid slot squashed.
REQ-027 stall=1 for 4 cycles with wb_vld=1 -> WB outputs, sr_*, FSM unchanged; stall release -> normal advance.
REQ-028 rst=0 asserted mid-SQ (sq_cnt=1) -> all outputs per REQ-020 immediately; after release first valid slot commits, squash=0.
